// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and data (load/store). Only one transaction is outstanding at a time. Data
// has priority; a streak counter forces a fetch grant after MAX_STREAK
// consecutive data grants that were made while fetch was waiting.
//
// state  | meaning
// IDLE   | no transaction outstanding, next request may be issued
// WAIT   | one transaction issued, waiting for mem_rvalid_i
module mem_port_arbiter #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req_i,
  input  logic [AWIDTH-1:0]   if_addr_i,
  input  logic                if_flush_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DWIDTH-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [AWIDTH-1:0]   d_addr_i,
  input  logic [DWIDTH-1:0]   d_wdata_i,
  input  logic [DWIDTH/8-1:0] d_be_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DWIDTH-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [AWIDTH-1:0]   mem_addr_o,
  output logic [DWIDTH-1:0]   mem_wdata_o,
  output logic [DWIDTH/8-1:0] mem_be_o,
  input  logic                mem_rvalid_i,
  input  logic [DWIDTH-1:0]   mem_rdata_i,
  output logic                err_o
);

  localparam int BWIDTH = DWIDTH / 8;
  localparam int SWIDTH = $clog2(MAX_STREAK + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_FETCH = 2'd1;
  localparam logic [1:0] OWN_DATA  = 2'd2;

  localparam logic [SWIDTH-1:0] STREAK_MAX = SWIDTH'(MAX_STREAK);

  logic [0:0]        state;
  logic [1:0]        owner;
  logic [SWIDTH-1:0] streak;
  logic              drop;
  logic              pick_data;
  logic              pick_fetch;
  logic              issue;
  logic              resp;

  // Arbitration: data wins unless fetch has been starved for MAX_STREAK grants.
  always_comb begin
    pick_data  = d_req_i && !(if_req_i && (streak == STREAK_MAX));
    pick_fetch = if_req_i && !pick_data;
    issue      = (state == ST_IDLE) && (pick_data || pick_fetch);
    resp       = (state == ST_WAIT) && mem_rvalid_i;
  end

  // Control state: FSM, owner, streak counter, flush drop flag and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      owner  <= OWN_NONE;
      streak <= '0;
      drop   <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          drop <= 1'b0;
          // A response with nothing outstanding is a protocol violation.
          if (mem_rvalid_i) err_o <= 1'b1;
          if (pick_data) begin
            state <= ST_WAIT;
            owner <= OWN_DATA;
            if (if_req_i) begin
              if (streak != STREAK_MAX) streak <= streak + 1'b1;
            end else begin
              streak <= '0;
            end
          end else if (pick_fetch) begin
            state  <= ST_WAIT;
            owner  <= OWN_FETCH;
            streak <= '0;
          end
        end
        ST_WAIT: begin
          if (if_flush_i && (owner == OWN_FETCH)) drop <= 1'b1;
          if (mem_rvalid_i) begin
            state <= ST_IDLE;
            owner <= OWN_NONE;
            drop  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

  // Issue path: grant pulse, memory request pulse and held payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_gnt_o    <= 1'b0;
      d_gnt_o     <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
    end else begin
      if_gnt_o  <= 1'b0;
      d_gnt_o   <= 1'b0;
      mem_req_o <= 1'b0;
      if (issue) begin
        mem_req_o <= 1'b1;
        if (pick_data) begin
          d_gnt_o     <= 1'b1;
          mem_we_o    <= d_we_i;
          mem_addr_o  <= d_addr_i;
          mem_wdata_o <= d_wdata_i;
          mem_be_o    <= d_be_i;
        end else begin
          if_gnt_o    <= 1'b1;
          mem_we_o    <= 1'b0;
          mem_addr_o  <= if_addr_i;
          mem_wdata_o <= '0;
          mem_be_o    <= {BWIDTH{1'b1}};
        end
      end
    end
  end

  // Response path: route the memory response to its owner, unless flushed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      d_rvalid_o  <= 1'b0;
      d_rdata_o   <= '0;
    end else begin
      if_rvalid_o <= 1'b0;
      d_rvalid_o  <= 1'b0;
      if (resp) begin
        if ((owner == OWN_FETCH) && !drop && !if_flush_i) begin
          if_rvalid_o <= 1'b1;
          if_rdata_o  <= mem_rdata_i;
        end else if (owner == OWN_DATA) begin
          d_rvalid_o <= 1'b1;
          // mem_we_o still holds the outstanding transaction's direction.
          d_rdata_o  <= mem_we_o ? '0 : mem_rdata_i;
        end
      end
    end
  end

endmodule
